// File: rtl/dtc_therm_window_accum.sv
// Converts thermometer-coded classifier results to levels, flags malformed codes and
// accumulates sum/count/bad/max over windows of WINDOW accepted samples.
module dtc_therm_window_accum #(
  parameter  int W      = 9,
  parameter  int WINDOW = 8,
  localparam int SUM_W  = $clog2(WINDOW * W + 1),
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_therm_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SUM_W-1:0] out_sum_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic [CNT_W-1:0] out_bad_o,
  output logic [3:0]       out_max_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_* stay stable while out_valid_o is high.
  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] acc_bad_q, acc_bad_d;
  logic [3:0]       acc_max_q, acc_max_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] out_bad_q, out_bad_d;
  logic [3:0]       out_max_q, out_max_d;

  logic [3:0]       level;
  logic             malformed;
  logic             accept;
  logic             close;
  logic [SUM_W-1:0] sum_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic [CNT_W-1:0] bad_upd;
  logic [3:0]       max_upd;

  assign level     = 4'($countones(in_therm_i));
  // Well-formed codes are 2^k-1; adding one clears every set bit only for those.
  assign malformed = |(in_therm_i & (in_therm_i + W'(1)));

  assign in_ready_o  = (state_q == ST_ACCUM) && !rst_i;
  assign out_valid_o = (state_q == ST_HOLD);
  assign accept      = in_valid_i && in_ready_o;

  assign sum_upd = acc_sum_q + (accept ? SUM_W'(level) : '0);
  assign cnt_upd = acc_cnt_q + CNT_W'(accept);
  assign bad_upd = acc_bad_q + CNT_W'(accept && malformed);
  assign max_upd = (accept && (level > acc_max_q)) ? level : acc_max_q;

  assign close = (state_q == ST_ACCUM) &&
                 ((accept && (acc_cnt_q == CNT_W'(WINDOW - 1))) ||
                  (flush_i && ((acc_cnt_q != '0) || accept)));

  always_comb begin
    state_d   = state_q;
    acc_sum_d = acc_sum_q;
    acc_cnt_d = acc_cnt_q;
    acc_bad_d = acc_bad_q;
    acc_max_d = acc_max_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_bad_d = out_bad_q;
    out_max_d = out_max_q;
    case (state_q)
      ST_ACCUM: begin
        if (close) begin
          out_sum_d = sum_upd;
          out_cnt_d = cnt_upd;
          out_bad_d = bad_upd;
          out_max_d = max_upd;
          acc_sum_d = '0;
          acc_cnt_d = '0;
          acc_bad_d = '0;
          acc_max_d = '0;
          state_d   = ST_HOLD;
        end else begin
          acc_sum_d = sum_upd;
          acc_cnt_d = cnt_upd;
          acc_bad_d = bad_upd;
          acc_max_d = max_upd;
        end
      end
      ST_HOLD: begin
        if (out_ready_i) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_ACCUM;
      acc_sum_q <= '0;
      acc_cnt_q <= '0;
      acc_bad_q <= '0;
      acc_max_q <= '0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_bad_q <= '0;
      out_max_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_sum_q <= acc_sum_d;
      acc_cnt_q <= acc_cnt_d;
      acc_bad_q <= acc_bad_d;
      acc_max_q <= acc_max_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_bad_q <= out_bad_d;
      out_max_q <= out_max_d;
    end
  end

  assign out_sum_o   = out_sum_q;
  assign out_count_o = out_cnt_q;
  assign out_bad_o   = out_bad_q;
  assign out_max_o   = out_max_q;

endmodule

// File: tb/tb_dtc_therm_window_accum.sv
// Bench for dtc_therm_window_accum: directed window table plus random traffic against a
// window-level reference model.
module tb_dtc_therm_window_accum;

  localparam int W      = 9;
  localparam int WINDOW = 8;
  localparam int SUM_W  = $clog2(WINDOW * W + 1);
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int RES_W  = SUM_W + 2 * CNT_W + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_therm = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_bad;
  logic [3:0]       out_max;

  int errors = 0;
  int checks = 0;

  // Reference model: levels of the open window, pending flag and expected results.
  int               m_lv[$];
  int               m_bd[$];
  bit               m_busy = 1'b0;
  logic [RES_W-1:0] exp_q[$];

  typedef struct {
    int           n;
    logic [W-1:0] codes[8];
    int           fmode;   // 0: none, 1: flush after last sample, 2: flush with last sample
    int           hold;
    int           e_sum, e_cnt, e_bad, e_max;
  } vec_t;
  vec_t tv[6];

  dtc_therm_window_accum #(.W(W), .WINDOW(WINDOW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_therm_i  (in_therm),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_count_o (out_count),
    .out_bad_o   (out_bad),
    .out_max_o   (out_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_level(input logic [W-1:0] c);
    int n = 0;
    for (int b = 0; b < W; b++) if (c[b]) n++;
    return n;
  endfunction

  function automatic int ref_bad(input logic [W-1:0] c);
    for (int k = 0; k <= W; k++) if (int'(c) == (1 << k) - 1) return 0;
    return 1;
  endfunction

  task automatic model_check_and_update();
    int s, b, mx, n;
    bit acc;
    logic [RES_W-1:0] e;
    chk("in_ready", int'(in_ready), int'(!m_busy));
    chk("out_valid", int'(out_valid), int'(m_busy));
    chk("acc_cnt_below_window", int'(dut.acc_cnt_q < CNT_W'(WINDOW)), 1);
    if (out_valid) chk("out_count_nonzero", int'(out_count != '0), 1);
    if (m_busy && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_sum",   int'(out_sum),   int'(e[RES_W-1 -: SUM_W]));
      chk("out_count", int'(out_count), int'(e[2*CNT_W+3 -: CNT_W]));
      chk("out_bad",   int'(out_bad),   int'(e[CNT_W+3 -: CNT_W]));
      chk("out_max",   int'(out_max),   int'(e[3:0]));
    end
    if (m_busy) begin
      if (out_ready) begin
        void'(exp_q.pop_front());
        m_busy = 1'b0;
      end
    end else begin
      acc = in_valid;
      if (acc) begin
        m_lv.push_back(ref_level(in_therm));
        m_bd.push_back(ref_bad(in_therm));
      end
      if ((acc && m_lv.size() == WINDOW) || (flush && m_lv.size() > 0)) begin
        s = 0; b = 0; mx = 0; n = m_lv.size();
        foreach (m_lv[i]) begin
          s += m_lv[i];
          b += m_bd[i];
          if (m_lv[i] > mx) mx = m_lv[i];
        end
        exp_q.push_back({SUM_W'(s), CNT_W'(n), CNT_W'(b), 4'(mx)});
        m_lv.delete();
        m_bd.delete();
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] t, input logic f, input logic r,
                      input int hand);
    in_valid  = v;
    in_therm  = t;
    flush     = f;
    out_ready = r;
    @(negedge clk);
    if (hand >= 0) begin
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_sum",   int'(out_sum),   tv[hand].e_sum);
      chk("tbl_count", int'(out_count), tv[hand].e_cnt);
      chk("tbl_bad",   int'(out_bad),   tv[hand].e_bad);
      chk("tbl_max",   int'(out_max),   tv[hand].e_max);
    end
    model_check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_max", int'(out_max) + int'(out_bad), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_lv.delete();
    m_bd.delete();
    exp_q.delete();
    m_busy = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    for (int i = 0; i < tv[idx].n; i++)
      step(1'b1, tv[idx].codes[i], (tv[idx].fmode == 2 && i == tv[idx].n - 1), 1'b0, -1);
    if (tv[idx].fmode == 1) step(1'b0, '0, 1'b1, 1'b0, -1);
    for (int h = 0; h < tv[idx].hold; h++) step(1'b0, '0, 1'b1, 1'b0, idx);
    step(1'b0, '0, 1'b0, 1'b1, idx);
    step(1'b0, '0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    logic [W-1:0] c;
    tv[0] = '{n: 8, codes: '{default: 9'h00F}, fmode: 0, hold: 0,
              e_sum: 32, e_cnt: 8, e_bad: 0, e_max: 4};
    tv[1] = '{n: 8, codes: '{9'h000, 9'h001, 9'h003, 9'h007, 9'h00F, 9'h01F, 9'h03F, 9'h07F},
              fmode: 0, hold: 5, e_sum: 28, e_cnt: 8, e_bad: 0, e_max: 7};
    tv[2] = '{n: 3, codes: '{default: 9'h1FF}, fmode: 1, hold: 1,
              e_sum: 27, e_cnt: 3, e_bad: 0, e_max: 9};
    tv[3] = '{n: 8, codes: '{9'h02F, 9'h100, 9'h003, 9'h003, 9'h003, 9'h003, 9'h003, 9'h003},
              fmode: 0, hold: 0, e_sum: 18, e_cnt: 8, e_bad: 2, e_max: 5};
    tv[4] = '{n: 4, codes: '{9'h003, 9'h003, 9'h003, 9'h007, 9'h000, 9'h000, 9'h000, 9'h000},
              fmode: 2, hold: 0, e_sum: 9, e_cnt: 4, e_bad: 0, e_max: 3};
    tv[5] = '{n: 8, codes: '{default: 9'h001}, fmode: 0, hold: 0,
              e_sum: 8, e_cnt: 8, e_bad: 0, e_max: 1};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_vec(i);
      if (i == 2) begin
        // Flush with an empty window must not produce a result.
        step(1'b0, '0, 1'b1, 1'b1, -1);
        step(1'b0, '0, 1'b1, 1'b1, -1);
        step(1'b0, '0, 1'b0, 1'b1, -1);
      end
    end

    for (int i = 0; i < 5; i++) step(1'b1, 9'h07F, 1'b0, 1'b1, -1);
    do_reset();
    run_vec(5);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 3) != 0) c = W'((1 << $urandom_range(0, W)) - 1);
      else c = W'($urandom);
      step($urandom_range(0, 3) != 0, c, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, -1);
      if (cyc == 2000) do_reset();
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, -1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
